// File: rtl/dvi_timing_pkg.sv
// dvi_timing_pkg: 640x480@60 default timing, coordinate width and total-count helpers
// Shared by the video timing generator and anything that needs the same frame geometry.
package dvi_timing_pkg;
   localparam int COORD_W      = 12;
   localparam int MAX_TOTAL    = 1 << COORD_W;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction
endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters plus a two-stage pipeline producing fetch requests and DVI syncs
// Ports:
//   clk_pixel            pixel clock
//   reset                synchronous active-high reset
//   enable               run timing; low parks counters at the origin
//   pix_req, req_x/y     stage 1: pixel fetch request and its coordinate
//   de, hsync, vsync     stage 2: straight to the DVI encoder
//   x, y                 stage 2: coordinate aligned with de
//   line_start           stage 2: pulse for h=0
//   frame_start          stage 2: pulse for h=0, v=0
module video_timing_gen
   import dvi_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic               clk_pixel,
   input  logic               reset,
   input  logic               enable,
   output logic               pix_req,
   output logic [COORD_W-1:0] req_x,
   output logic [COORD_W-1:0] req_y,
   output logic               de,
   output logic               hsync,
   output logic               vsync,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start
);
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || H_ACTIVE == 0 || H_FP == 0 ||
       H_SYNC == 0 || H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
      $error("video_timing_gen: timing parameters out of range");
   end

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [COORD_W-1:0] h, v;
   logic               s1_hs, s1_vs, s1_ls, s1_fs;

   always_ff @(posedge clk_pixel) begin
      if (reset || !enable) begin
         h <= '0;
         v <= '0;
      end else begin
         h <= (h == H_LAST) ? '0 : h + 1'b1;
         if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;
      end
   end

   // Stage-1 sync/pulse flags mean "asserted" regardless of polarity; polarity is applied
   // only at stage 2. Gating with enable makes a disabled pipeline drain to idle.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         pix_req     <= 1'b0;
         req_x       <= '0;
         req_y       <= '0;
         s1_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s1_ls       <= 1'b0;
         s1_fs       <= 1'b0;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_req     <= enable && h < H_ACT && v < V_ACT;
         req_x       <= h;
         req_y       <= v;
         s1_hs       <= enable && h >= HS_START && h < HS_END;
         s1_vs       <= enable && v >= VS_START && v < VS_END;
         s1_ls       <= enable && h == '0;
         s1_fs       <= enable && h == '0 && v == '0;
         de          <= pix_req;
         x           <= req_x;
         y           <= req_y;
         hsync       <= s1_hs ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
         line_start  <= s1_ls;
         frame_start <= s1_fs;
      end
   end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed and table-driven checks of video_timing_gen on a 7x5 raster
module tb_video_timing_gen;
   logic        clk_pixel = 1'b0, reset = 1'b1, enable = 1'b0;
   logic        pix_req, de, hsync, vsync, line_start, frame_start;
   logic [11:0] req_x, req_y, x, y;
   int          tests = 0, errs = 0;
   int          n_de = 0, n_vs = 0, n_fs = 0, last_fs = -1;

   typedef struct {
      logic pr;
      int   rx, ry;
      logic de;
      int   x, y;
      logic hs, vs, ls, fs;
   } vec_t;

   vec_t tbl [9];

   always #5 clk_pixel = ~clk_pixel;

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .enable(enable),
      .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
      .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic tick;
      logic pr, rs;
      logic [11:0] rx, ry;
      pr = pix_req;
      rx = req_x;
      ry = req_y;
      rs = reset;
      @(posedge clk_pixel);
      #1;
      if (!rs) begin
         chk("pipe_de", 32'(de), 32'(pr));
         if (pr) begin
            chk("pipe_x", 32'(x), 32'(rx));
            chk("pipe_y", 32'(y), 32'(ry));
         end
      end
   endtask

   function automatic vec_t model(input int k);
      vec_t e;
      int h1, v1, h2, v2;
      h1 = (k - 1) % 7;
      v1 = ((k - 1) / 7) % 5;
      h2 = (k - 2) % 7;
      v2 = ((k - 2) / 7) % 5;
      e.pr = h1 < 4 && v1 < 2;
      e.rx = h1;
      e.ry = v1;
      e.de = h2 < 4 && v2 < 2;
      e.x  = h2;
      e.y  = v2;
      e.hs = h2 != 5;
      e.vs = v2 != 3;
      e.ls = h2 == 0;
      e.fs = h2 == 0 && v2 == 0;
      return e;
   endfunction

   task automatic chk_vec(input string t, input vec_t e);
      chk({t, ".pix_req"}, 32'(pix_req), 32'(e.pr));
      chk({t, ".req_x"}, 32'(req_x), e.rx);
      chk({t, ".req_y"}, 32'(req_y), e.ry);
      chk({t, ".de"}, 32'(de), 32'(e.de));
      chk({t, ".x"}, 32'(x), e.x);
      chk({t, ".y"}, 32'(y), e.y);
      chk({t, ".hsync"}, 32'(hsync), 32'(e.hs));
      chk({t, ".vsync"}, 32'(vsync), 32'(e.vs));
      chk({t, ".line_start"}, 32'(line_start), 32'(e.ls));
      chk({t, ".frame_start"}, 32'(frame_start), 32'(e.fs));
   endtask

   task automatic chk_idle(input string t);
      chk({t, ".pix_req"}, 32'(pix_req), 0);
      chk({t, ".de"}, 32'(de), 0);
      chk({t, ".hsync"}, 32'(hsync), 1);
      chk({t, ".vsync"}, 32'(vsync), 1);
      chk({t, ".line_start"}, 32'(line_start), 0);
      chk({t, ".frame_start"}, 32'(frame_start), 0);
   endtask

   task automatic chk_zero_xy(input string t);
      chk({t, ".req_x"}, 32'(req_x), 0);
      chk({t, ".req_y"}, 32'(req_y), 0);
      chk({t, ".x"}, 32'(x), 0);
      chk({t, ".y"}, 32'(y), 0);
   endtask

   task automatic acc(input int k);
      if (de === 1'b1) n_de++;
      if (vsync === 1'b0) n_vs++;
      if (frame_start === 1'b1) begin
         n_fs++;
         if (last_fs >= 0) chk("fs_gap", k - last_fs, 35);
         last_fs = k;
      end
   endtask

   initial begin
      //              pr rx ry de x  y  hs vs ls fs
      tbl[0] = '{1'b1, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1, 0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{1'b1, 2, 0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 3, 0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 4, 0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 5, 0, 1'b0, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 6, 0, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 0, 1, 1'b0, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 1, 1, 1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      enable = 1'b1;
      tick;
      tick;
      chk_idle("rst");
      chk_zero_xy("rst");
      reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick;
         chk_vec($sformatf("tbl%0d", k), tbl[k-1]);
         acc(k);
      end
      for (int k = 10; k <= 106; k++) begin
         tick;
         chk_vec($sformatf("run%0d", k), model(k));
         acc(k);
      end
      chk("de_per_3_frames", n_de, 24);
      chk("vsync_low_3_frames", n_vs, 21);
      chk("frame_starts", n_fs, 3);
      enable = 1'b0;
      tick;
      chk("drain.pix_req", 32'(pix_req), 0);
      chk("drain.de", 32'(de), 1);
      chk("drain.x", 32'(x), 0);
      chk("drain.y", 32'(y), 0);
      for (int i = 1; i < 10; i++) begin
         tick;
         chk_idle($sformatf("off%0d", i));
      end
      enable = 1'b1;
      tick;
      chk("reen1.pix_req", 32'(pix_req), 1);
      chk("reen1.req_x", 32'(req_x), 0);
      chk("reen1.req_y", 32'(req_y), 0);
      chk("reen1.de", 32'(de), 0);
      chk("reen1.frame_start", 32'(frame_start), 0);
      tick;
      chk("reen2.de", 32'(de), 1);
      chk("reen2.x", 32'(x), 0);
      chk("reen2.y", 32'(y), 0);
      chk("reen2.frame_start", 32'(frame_start), 1);
      chk("reen2.line_start", 32'(line_start), 1);
      repeat (10) tick;
      reset = 1'b1;
      tick;
      chk_idle("mid_rst");
      chk_zero_xy("mid_rst");
      tick;
      reset = 1'b0;
      tick;
      chk("rel1.pix_req", 32'(pix_req), 1);
      chk("rel1.de", 32'(de), 0);
      chk("rel1.frame_start", 32'(frame_start), 0);
      tick;
      chk("rel2.frame_start", 32'(frame_start), 1);
      chk("rel2.de", 32'(de), 1);
      chk("rel2.x", 32'(x), 0);
      chk("rel2.y", 32'(y), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
